// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Op encodings, FSM state enum and the iteration count.
package mdu_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit, 33-cycle latency.
// Ports: clk, rst_n (async, active low), start/op/A/B request,
//        busy, done pulse, div_by_zero (valid with done), hi, lo.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  // operand conditioning at launch
  logic             w_sgn;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_sgn   = ~op[0];
  assign w_sa    = w_sgn & A[WIDTH-1];
  assign w_sb    = w_sgn & B[WIDTH-1];
  assign w_a_mag = w_sa ? -A : A;
  assign w_b_mag = w_sb ? -B : B;

  // shift-add step: {p_hi,p_lo} holds partial product
  // over the not-yet-consumed multiplier bits
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_m_hi;
  logic [WIDTH-1:0] w_m_lo;

  assign w_madd = {1'b0, r_p_hi}
                + (r_p_lo[0] ? {1'b0, r_b} : '0);
  assign w_m_hi = w_madd[WIDTH:1];
  assign w_m_lo = {w_madd[0], r_p_lo[WIDTH-1:1]};

  // restoring divide step: p_hi is the partial
  // remainder, p_lo shifts dividend out / quotient in.
  // A passing subtract always fits in WIDTH bits.
  logic [WIDTH:0]   w_dsh;
  logic             w_dge;
  logic [WIDTH-1:0] w_dsub;
  logic [WIDTH-1:0] w_d_hi;
  logic [WIDTH-1:0] w_d_lo;

  assign w_dsh  = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_dge  = (w_dsh >= {1'b0, r_b});
  assign w_dsub = w_dsh[WIDTH-1:0] - r_b;
  assign w_d_hi = w_dge ? w_dsub : w_dsh[WIDTH-1:0];
  assign w_d_lo = {r_p_lo[WIDTH-2:0], w_dge};

  // sign correction for the final write
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod     = {r_p_hi, r_p_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  // divide by zero leaves |A| in the remainder,
  // so the sign fix restores hi = A
  assign w_quo_fix  = r_dz ? '1
                    : (r_neg_lo ? -r_p_lo : r_p_lo);
  assign w_rem_fix  = r_neg_hi ? -r_p_hi : r_p_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_b      <= '0;
      r_p_hi   <= '0;
      r_p_lo   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU,
              OP_DIV, OP_DIVU: begin
                r_state  <= S_CALC;
                r_cnt    <= '0;
                r_is_div <= op[1];
                r_dz     <= (B == '0);
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= w_sa;
                r_p_hi   <= '0;
                r_p_lo   <= op[1] ? w_a_mag : w_b_mag;
                r_b      <= op[1] ? w_b_mag : w_a_mag;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (r_is_div) begin
            r_p_hi <= w_d_hi;
            r_p_lo <= w_d_lo;
          end else begin
            r_p_hi <= w_m_hi;
            r_p_lo <= w_m_lo;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_dbz   <= r_is_div & r_dz;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
